bpsk_demodulator: RTL and testbench

Coherent BPSK receiver that recovers the encoded word stream from the carrier sample stream produced by the transceiver's BPSK modulator. Correlates each symbol period against a square-wave replica of the carrier with an integrate-and-dump accumulator and slices one bit per symbol. Assembles bits MSB-first into DATA_WIDTH-bit words for the Hamming decoder. Sits on the receive side of the transceiver, between the sample source (ADC/loopback) and hamming_decoder.

---
 rtl/bpsk_demodulator.sv | 116 +++++++++++
 tb/tb_bpsk_demodulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: integrate-and-dump correlation against a square-wave
// carrier replica, one bit per symbol, bits packed MSB-first into DATA_WIDTH words.
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [SAMPLE_WIDTH-1:0] data,
  output logic                    bit_q,
  output logic                    bit_valid,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    done
);

  localparam int CNT_W = $clog2(SAMPLE_NUMBER);
  localparam int ACC_W = SAMPLE_WIDTH + CNT_W + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLE_NUMBER - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_reg, state_next;
  logic   accept;

  logic [CNT_W-1:0]      sample_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [ACC_W-1:0]      acc_reg;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic [CNT_W-1:0]      cnt_base;
  logic [BIT_W-1:0]      bit_base;
  logic [ACC_W-1:0]      acc_base;
  logic [DATA_WIDTH-1:0] shift_base;
  logic [ACC_W-1:0]      data_ext;
  logic [ACC_W-1:0]      acc_sum;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  ref_pos;
  logic                  decision;
  logic                  symbol_end;
  logic                  word_end;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en || sync) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Samples are integrated from the very first strobe, including the one that leaves IDLE.
  always_comb begin
    accept = 1'b0;
    case (state_reg)
      IDLE:    accept = en;
      RUN:     accept = en;
      default: accept = 1'b0;
    endcase
  end

  // sync behaves as if the counters were already cleared, so a same-cycle sample is sample 0.
  always_comb begin
    cnt_base   = sync ? '0 : sample_cnt_reg;
    bit_base   = sync ? '0 : bit_cnt_reg;
    acc_base   = sync ? '0 : acc_reg;
    shift_base = sync ? '0 : shift_reg;
    data_ext   = {{(ACC_W - SAMPLE_WIDTH){data[SAMPLE_WIDTH-1]}}, data};
    ref_pos    = ~cnt_base[CNT_W-1];
    acc_sum    = ref_pos ? (acc_base + data_ext) : (acc_base - data_ext);
    decision   = ~acc_sum[ACC_W-1];
    shifted    = {shift_base[DATA_WIDTH-2:0], decision};
    symbol_end = accept && (cnt_base == LAST_SAMPLE);
    word_end   = symbol_end && (bit_base == LAST_BIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      acc_reg        <= '0;
      shift_reg      <= '0;
      bit_q          <= 1'b0;
      bit_valid      <= 1'b0;
      q              <= '0;
      done           <= 1'b0;
    end else begin
      bit_valid      <= symbol_end;
      done           <= word_end;
      sample_cnt_reg <= cnt_base;
      bit_cnt_reg    <= bit_base;
      acc_reg        <= acc_base;
      shift_reg      <= shift_base;
      if (accept) begin
        sample_cnt_reg <= cnt_base + 1'b1;
        acc_reg        <= symbol_end ? '0 : acc_sum;
        if (symbol_end) begin
          bit_q       <= decision;
          shift_reg   <= shifted;
          bit_cnt_reg <= word_end ? '0 : (bit_base + 1'b1);
          if (word_end) q <= shifted;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Randomized bench for bpsk_demodulator; expected bits/words come from a per-symbol
// correlation sum computed directly over the transmitted samples.
module tb_bpsk_demodulator;

  localparam int SN = 256;
  localparam int SW = 12;
  localparam int DW = 12;
  localparam int WORD_SAMPLES = SN * DW;

  logic          clk = 1'b0;
  logic          rst, en, sync;
  logic [SW-1:0] data;
  logic          bit_q, bit_valid, done;
  logic [DW-1:0] q;

  bpsk_demodulator #(.SAMPLE_NUMBER(SN), .SAMPLE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .data(data),
    .bit_q(bit_q), .bit_valid(bit_valid), .q(q), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: collect a symbol's samples, correlate with +1/-1 halves, slice.
  int sym_samples[$];
  int exp_bits[$];
  int exp_words[$];
  int word_acc  = 0;
  int word_nbit = 0;

  function automatic void model_clear();
    sym_samples.delete();
    word_acc  = 0;
    word_nbit = 0;
  endfunction

  function automatic void model_accept(input int d);
    longint sum;
    int b;
    sym_samples.push_back(d);
    if (sym_samples.size() == SN) begin
      sum = 0;
      for (int i = 0; i < SN; i++) sum += (i < SN / 2) ? sym_samples[i] : -sym_samples[i];
      b = (sum >= 0) ? 1 : 0;
      exp_bits.push_back(b);
      word_acc = word_acc * 2 + b;
      word_nbit++;
      if (word_nbit == DW) begin
        exp_words.push_back(word_acc);
        word_acc  = 0;
        word_nbit = 0;
      end
      sym_samples.delete();
    end
  endfunction

  // Monitor on the falling edge: pulses against model, pulse width, output stability.
  int bits_seen = 0;
  int words_seen = 0;
  int last_done_cyc = 0;
  logic prev_bv = 1'b0, prev_done = 1'b0, prev_bit = 1'b0;
  logic [DW-1:0] prev_q = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bit_valid) begin
        bits_seen++;
        if (exp_bits.size() == 0) check("bit_unexpected", 1, 0);
        else check("bit_q", bit_q, exp_bits.pop_front());
      end
      if (done) begin
        words_seen++;
        last_done_cyc = cyc;
        if (exp_words.size() == 0) check("done_unexpected", 1, 0);
        else check("q", q, exp_words.pop_front());
      end
      if (bit_valid && prev_bv) check("bit_valid_width", 2, 1);
      if (done && prev_done) check("done_width", 2, 1);
      if (!done && q != prev_q) check("q_stable", q, prev_q);
      if (!bit_valid && bit_q != prev_bit) check("bit_q_stable", bit_q, prev_bit);
    end
    prev_bv   = bit_valid;
    prev_done = done;
    prev_q    = q;
    prev_bit  = bit_q;
  end

  task automatic idle();
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic put(input int v);
    en   = 1'b1;
    data = SW'(v);
    @(posedge clk); #1;
    model_accept(v);
    en = 1'b0;
  endtask

  int sync_cyc = 0;
  task automatic do_sync();
    en   = 1'b0;
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    sync_cyc = cyc;
    model_clear();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
    exp_bits.delete();
    exp_words.delete();
    model_clear();
    check("rst_bit_q", bit_q, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_q", q, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
  endtask

  // mode: 0 = +/-1000 square, 1 = all zero, 2 = extremes, 3 = random amplitude + noise.
  // gaps: 0 = none, 1 = idle before every sample, 2 = random idles.
  task automatic send_word(input int w, input int mode, input int gaps, input int nsamp);
    int amp;
    amp = int'($urandom_range(1, 900));
    for (int k = 0; k < nsamp; k++) begin
      int  i, j, b, v;
      bit  first;
      i = k / SN;
      j = k % SN;
      b = (w >> (DW - 1 - i)) & 1;
      first = (j < SN / 2);
      case (mode)
        0:       v = (int'(first) == b) ? 1000 : -1000;
        1:       v = 0;
        2:       v = first ? -2048 : 2047;
        default: v = ((int'(first) == b) ? amp : -amp) + int'($urandom_range(0, 1600)) - 800;
      endcase
      if (gaps == 1) idle();
      if (gaps == 2 && $urandom_range(0, 3) == 0) idle();
      put(v);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) idle();
  endtask

  int b0, w0;

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; data = '0;
    do_reset(4);

    // Reference word 0xA5C with timing of the done pulse relative to sync.
    do_sync();
    b0 = bits_seen; w0 = words_seen;
    send_word(12'hA5C, 0, 0, WORD_SAMPLES);
    settle();
    check("a5c_q", q, 12'hA5C);
    check("a5c_bits", bits_seen - b0, DW);
    check("a5c_words", words_seen - w0, 1);
    check("a5c_latency", last_done_cyc - sync_cyc, WORD_SAMPLES);

    // Zero correlation slices to 1.
    send_word(0, 1, 0, WORD_SAMPLES);
    settle();
    check("zero_q", q, 12'hFFF);

    // Full-scale extremes, no overflow.
    send_word(0, 2, 0, WORD_SAMPLES);
    settle();
    check("extreme_q", q, 12'h000);

    // en toggled every cycle.
    do_sync();
    send_word(12'h3C3, 0, 1, WORD_SAMPLES);
    settle();
    check("toggle_q", q, 12'h3C3);
    check("toggle_latency", last_done_cyc - sync_cyc, 2 * WORD_SAMPLES);

    // Abandon a word with sync at sample 100 of bit 5.
    w0 = words_seen;
    send_word(12'hFFF, 0, 0, 5 * SN + 100);
    do_sync();
    send_word(12'h123, 0, 0, WORD_SAMPLES);
    settle();
    check("sync_words", words_seen - w0, 1);
    check("sync_q", q, 12'h123);

    // Reset mid-word.
    send_word(12'h5A5, 0, 0, 1000);
    do_reset(3);
    w0 = words_seen;
    do_sync();
    send_word(12'h800, 0, 0, WORD_SAMPLES);
    settle();
    check("rst_words", words_seen - w0, 1);
    check("rst_q_after", q, 12'h800);

    // Random words with noise and random strobe gaps.
    do_sync();
    for (int n = 0; n < 4; n++) begin
      send_word(int'($urandom_range(0, 4095)), 3, 2, WORD_SAMPLES);
    end
    settle();
    check("rand_bits_left", exp_bits.size(), 0);
    check("rand_words_left", exp_words.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
